// File: rtl/npg_biphasic_gen_pkg.sv
// npg_pkg: shared state encoding and helpers for the biphasic pulse generator.
package npg_pkg;

   typedef enum logic [2:0] {IDLE, PHASE1, GAP, PHASE2, DISCH} npg_state_t;

   localparam int MIN_W = 16;

   function automatic int code_max(input int sw_w);
      return (1 << sw_w) - 1;
   endfunction

   function automatic logic [MIN_W-1:0] min_sel(input logic [MIN_W-1:0] a, input logic [MIN_W-1:0] b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/npg_biphasic_gen_if.sv
// npg_if: configuration and switch-code bundle of the pulse generator.
// NPG_DISCHARGE_EN adds the discharge output.
interface npg_if #(
   parameter int FREQ_W  = 12,
   parameter int PHASE_W = 8,
   parameter int GAP_W   = 4,
   parameter int SW_W    = 4,
   parameter int RAMP_W  = 6
);
   logic               enable;
   logic [FREQ_W-1:0]  freq;
   logic [PHASE_W-1:0] phase_dur;
   logic [GAP_W-1:0]   gap_dur;
   logic [RAMP_W-1:0]  ramp;
   logic               cathodic_first;
   logic [SW_W-1:0]    up_code;
   logic [SW_W-1:0]    down_code;
   logic               clr_overrun;
   logic [SW_W-1:0]    up_switches;
   logic [SW_W-1:0]    down_switches;
   logic               busy;
   logic               overrun;
`ifdef NPG_DISCHARGE_EN
   logic               discharge;
`endif

   modport master (
      output enable, freq, phase_dur, gap_dur, ramp, cathodic_first, up_code, down_code, clr_overrun,
`ifdef NPG_DISCHARGE_EN
      input  discharge,
`endif
      input  up_switches, down_switches, busy, overrun
   );

   modport slave (
      input  enable, freq, phase_dur, gap_dur, ramp, cathodic_first, up_code, down_code, clr_overrun,
`ifdef NPG_DISCHARGE_EN
      output discharge,
`endif
      output up_switches, down_switches, busy, overrun
   );

endinterface

// File: rtl/npg_biphasic_gen_ramp.sv
// npg_ramp: amplitude level that steps up once every ramp completed pulses.
module npg_ramp
   import npg_pkg::*;
#(
   parameter int SW_W   = 4,
   parameter int RAMP_W = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pulse_done,
   input  logic [RAMP_W-1:0] ramp,
   input  logic              clear,
   output logic [SW_W-1:0]   level
);
   localparam logic [SW_W-1:0] CODE_MAX = SW_W'(code_max(SW_W));

   logic [SW_W-1:0]   r_level;
   logic [RAMP_W-1:0] r_cnt;
   logic [RAMP_W-1:0] w_cnt_inc;
   logic              w_step;

   assign w_cnt_inc = r_cnt + RAMP_W'(1);
   assign w_step    = (w_cnt_inc == ramp);
   assign level     = (ramp == '0) ? CODE_MAX : r_level;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         r_level <= SW_W'(1);
         r_cnt   <= '0;
      end else if (pulse_done && ramp != '0) begin
         r_cnt   <= w_step ? '0 : w_cnt_inc;
         r_level <= (w_step && r_level != CODE_MAX) ? r_level + SW_W'(1) : r_level;
      end
   end

endmodule

// File: rtl/npg_biphasic_gen.sv
// npg_biphasic_gen: periodic biphasic pulse generator driving H-bridge switch codes.
// NPG_DISCHARGE_EN adds a DISCH state with a discharge output after PHASE2.
module npg_biphasic_gen
   import npg_pkg::*;
#(
   parameter int FREQ_W  = 12,
   parameter int PHASE_W = 8,
   parameter int GAP_W   = 4,
   parameter int SW_W    = 4,
   parameter int RAMP_W  = 6
) (
   input  logic clk,
   input  logic reset,
   npg_if.slave bus
);
   localparam int TMR_W = (PHASE_W > GAP_W) ? PHASE_W : GAP_W;

   npg_state_t         r_state, w_next;
   logic [FREQ_W-1:0]  r_cnt;
   logic [TMR_W-1:0]   r_tmr, w_tmr, w_pd_m1, w_gap_m1;
   logic [PHASE_W-1:0] r_pd, w_pd;
   logic [GAP_W-1:0]   r_gap, w_gap;
   logic               r_cf, w_cf;
   logic [SW_W-1:0]    r_up, r_dn, w_up, w_dn;
   logic [SW_W-1:0]    w_level, w_a_up, w_a_dn, w_up_sw, w_dn_sw, r_up_sw, r_dn_sw;
   logic               r_busy, r_ovr;
   logic               w_tick, w_latch, w_done, w_clr, w_fwd, w_rev;

   assign w_tick  = bus.enable && (r_cnt == bus.freq);
   assign w_latch = (r_state == IDLE) && w_tick;
   assign w_clr   = !bus.enable && (r_state == IDLE);

   // next-cycle shadow values, so the first pulse cycle already uses fresh settings
   assign w_pd  = w_latch ? bus.phase_dur      : r_pd;
   assign w_gap = w_latch ? bus.gap_dur        : r_gap;
   assign w_cf  = w_latch ? bus.cathodic_first : r_cf;
   assign w_up  = w_latch ? bus.up_code        : r_up;
   assign w_dn  = w_latch ? bus.down_code      : r_dn;

   assign w_pd_m1  = (w_pd == '0)  ? '0 : TMR_W'(w_pd) - TMR_W'(1);
   assign w_gap_m1 = (w_gap == '0) ? '0 : TMR_W'(w_gap) - TMR_W'(1);

   always_comb begin
      w_next = r_state;
      w_tmr  = (r_tmr == '0) ? '0 : r_tmr - TMR_W'(1);
      w_done = 1'b0;
      case (r_state)
         IDLE: if (w_tick) begin
            w_next = PHASE1;
            w_tmr  = w_pd_m1;
         end
         PHASE1: if (r_tmr == '0) begin
            w_next = (w_gap != '0) ? GAP : PHASE2;
            w_tmr  = (w_gap != '0) ? w_gap_m1 : w_pd_m1;
         end
         GAP: if (r_tmr == '0) begin
            w_next = PHASE2;
            w_tmr  = w_pd_m1;
         end
         PHASE2: if (r_tmr == '0) begin
            w_done = 1'b1;
`ifdef NPG_DISCHARGE_EN
            w_next = DISCH;
            w_tmr  = w_gap_m1;
`else
            w_next = IDLE;
`endif
         end
`ifdef NPG_DISCHARGE_EN
         DISCH: if (r_tmr == '0) w_next = IDLE;
`endif
         default: w_next = IDLE;
      endcase
   end

   npg_ramp #(.SW_W(SW_W), .RAMP_W(RAMP_W)) u_ramp (
      .clk        (clk),
      .reset      (reset),
      .pulse_done (w_done),
      .ramp       (bus.ramp),
      .clear      (w_clr),
      .level      (w_level)
   );

   assign w_a_up  = SW_W'(min_sel(MIN_W'(w_up), MIN_W'(w_level)));
   assign w_a_dn  = SW_W'(min_sel(MIN_W'(w_dn), MIN_W'(w_level)));
   assign w_fwd   = ((w_next == PHASE1) && !w_cf) || ((w_next == PHASE2) && w_cf);
   assign w_rev   = ((w_next == PHASE2) && !w_cf) || ((w_next == PHASE1) && w_cf);
   assign w_up_sw = w_fwd ? w_a_up : (w_rev ? w_a_dn : '0);
   assign w_dn_sw = w_fwd ? w_a_dn : (w_rev ? w_a_up : '0);

`ifdef NPG_DISCHARGE_EN
   logic r_disch;
   assign bus.discharge = r_disch;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_tmr   <= '0;
         r_pd    <= '0;
         r_gap   <= '0;
         r_cf    <= 1'b0;
         r_up    <= '0;
         r_dn    <= '0;
         r_up_sw <= '0;
         r_dn_sw <= '0;
         r_busy  <= 1'b0;
         r_ovr   <= 1'b0;
`ifdef NPG_DISCHARGE_EN
         r_disch <= 1'b0;
`endif
      end else begin
         r_state <= w_next;
         r_cnt   <= (!bus.enable || r_cnt == bus.freq) ? '0 : r_cnt + FREQ_W'(1);
         r_tmr   <= w_tmr;
         r_pd    <= w_pd;
         r_gap   <= w_gap;
         r_cf    <= w_cf;
         r_up    <= w_up;
         r_dn    <= w_dn;
         r_up_sw <= w_up_sw;
         r_dn_sw <= w_dn_sw;
         r_busy  <= (w_next != IDLE);
         r_ovr   <= (w_tick && r_state != IDLE) || (r_ovr && !bus.clr_overrun);
`ifdef NPG_DISCHARGE_EN
         r_disch <= (w_next == DISCH);
`endif
      end
   end

   assign bus.up_switches   = r_up_sw;
   assign bus.down_switches = r_dn_sw;
   assign bus.busy          = r_busy;
   assign bus.overrun       = r_ovr;

endmodule

// File: tb/tb_npg_biphasic_gen.sv
// tb_npg_biphasic_gen: scoreboard bench; expected busy-cycle switch codes are queued, a monitor compares them.
module tb_npg_biphasic_gen;

   typedef struct {
      logic [3:0] up;
      logic [3:0] dn;
      int         t;
      bit         ref_en;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   exp_t q[$];
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   npg_if bus ();

   npg_biphasic_gen dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic cfg(input int fr, input int pd, input int gp, input int rp, input bit cf,
                      input logic [3:0] up, input logic [3:0] dn);
      bus.freq = 12'(fr);
      bus.phase_dur = 8'(pd);
      bus.gap_dur = 4'(gp);
      bus.ramp = 6'(rp);
      bus.cathodic_first = cf;
      bus.up_code = up;
      bus.down_code = dn;
   endtask

   // up/dn are the already-clipped amplitudes; t is the start spacing to check (0 = skip)
   task automatic push_pulse(input logic [3:0] up, input logic [3:0] dn, input int pd, input int gp,
                             input bit cf, input int t, input bit ref_en, input int lim);
      exp_t e;
      int   p;
      bit   ph1, ph2, fwd, rev;
      p = (pd == 0) ? 1 : pd;
      for (int i = 0; i < 2 * p + gp; i++) begin
         ph1 = (i < p);
         ph2 = (i >= p + gp);
         fwd = (ph1 && !cf) || (ph2 && cf);
         rev = (ph2 && !cf) || (ph1 && cf);
         e.up = fwd ? up : (rev ? dn : 4'h0);
         e.dn = fwd ? dn : (rev ? up : 4'h0);
         e.t = (i == 0) ? t : 0;
         e.ref_en = ref_en;
         if (lim == 0 || i < lim) q.push_back(e);
      end
   endtask

   task automatic wait_empty();
      int k = 0;
      while (q.size() != 0 && k < 3000) begin
         @(posedge clk);
         k++;
      end
      #1;
      if (q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout actual=%0d pending required=0", q.size());
      end
   endtask

   task automatic drain();
      wait_empty();
      bus.enable = 1'b0;
      wait_cyc(3);
   endtask

   initial begin : monitor
      int   cyc = 0, en_cyc = 0, last = 0, d;
      bit   en_d = 1'b0, busy_d = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (bus.enable === 1'b1 && !en_d) en_cyc = cyc;
         en_d = (bus.enable === 1'b1);
         if (bus.busy === 1'b1) begin
            if (q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_busy actual up=%0h dn=%0h required idle", bus.up_switches, bus.down_switches);
            end else begin
               e = q.pop_front();
               checks++;
               if ({bus.up_switches, bus.down_switches} !== {e.up, e.dn}) begin
                  failures++;
                  $display("FAIL switches actual=%0h/%0h required=%0h/%0h at cycle %0d",
                           bus.up_switches, bus.down_switches, e.up, e.dn, cyc);
               end
               if (e.t != 0) begin
                  checks++;
                  d = cyc - (e.ref_en ? en_cyc : last);
                  if (d != e.t) begin
                     failures++;
                     $display("FAIL pulse_spacing actual=%0d required=%0d", d, e.t);
                  end
               end
            end
         end
         if (bus.busy === 1'b1 && !busy_d) last = cyc;
         busy_d = (bus.busy === 1'b1);
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int lvl;
      bus.enable = 1'b0;
      bus.clr_overrun = 1'b0;
      cfg(19, 3, 2, 0, 0, 4'hA, 4'h5);
      wait_cyc(3);
      chk("rst_up", 32'(bus.up_switches), 0);
      chk("rst_dn", 32'(bus.down_switches), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_ovr", 32'(bus.overrun), 0);
      reset = 1'b0;
      wait_cyc(2);

      // basic pulse train, anodic first, with gap
      push_pulse(4'hA, 4'h5, 3, 2, 0, 20, 1, 0);
      push_pulse(4'hA, 4'h5, 3, 2, 0, 20, 0, 0);
      push_pulse(4'hA, 4'h5, 3, 2, 0, 20, 0, 0);
      bus.enable = 1'b1;
      drain();

      // cathodic first, no gap
      cfg(19, 3, 0, 0, 1, 4'hA, 4'h5);
      push_pulse(4'hA, 4'h5, 3, 0, 1, 20, 1, 0);
      push_pulse(4'hA, 4'h5, 3, 0, 1, 20, 0, 0);
      bus.enable = 1'b1;
      drain();

      // ramp 1,1,2,2,... saturating at F; down code clipped at 3
      cfg(9, 2, 0, 2, 0, 4'hF, 4'h3);
      for (int n = 1; n <= 32; n++) begin
         lvl = 1 + (n - 1) / 2;
         if (lvl > 15) lvl = 15;
         push_pulse(4'(lvl), 4'((lvl < 3) ? lvl : 3), 2, 0, 0, 10, (n == 1), 0);
      end
      bus.enable = 1'b1;
      drain();

      // enable dropped in PHASE1 of pulse 3, then re-enable restarts ramp
      cfg(19, 3, 1, 2, 0, 4'hF, 4'h3);
      push_pulse(4'h1, 4'h1, 3, 1, 0, 20, 1, 0);
      push_pulse(4'h1, 4'h1, 3, 1, 0, 20, 0, 0);
      push_pulse(4'h2, 4'h2, 3, 1, 0, 20, 0, 0);
      bus.enable = 1'b1;
      wait_cyc(61);
      bus.enable = 1'b0;
      chk("drop_busy", 32'(bus.busy), 1);
      wait_empty();
      wait_cyc(30);
      chk("drop_ovr", 32'(bus.overrun), 0);
      push_pulse(4'h1, 4'h1, 3, 1, 0, 20, 1, 0);
      bus.enable = 1'b1;
      drain();

      // overrun: period 5, pulse 10 cycles
      cfg(4, 5, 0, 0, 0, 4'hA, 4'h5);
      push_pulse(4'hA, 4'h5, 5, 0, 0, 5, 1, 0);
      push_pulse(4'hA, 4'h5, 5, 0, 0, 15, 0, 0);
      bus.enable = 1'b1;
      wait_cyc(11);
      chk("ovr_set", 32'(bus.overrun), 1);
      bus.clr_overrun = 1'b1;
      wait_cyc(1);
      chk("ovr_clr", 32'(bus.overrun), 0);
      bus.clr_overrun = 1'b0;
      wait_cyc(2);
      bus.clr_overrun = 1'b1;
      wait_cyc(1);
      chk("ovr_set_wins", 32'(bus.overrun), 1);
      wait_cyc(1);
      chk("ovr_clr2", 32'(bus.overrun), 0);
      bus.clr_overrun = 1'b0;
      drain();
      chk("ovr_sticky", 32'(bus.overrun), 1);

      // reset during PHASE2
      cfg(19, 3, 2, 0, 0, 4'hA, 4'h5);
      push_pulse(4'hA, 4'h5, 3, 2, 0, 20, 1, 6);
      bus.enable = 1'b1;
      wait_cyc(25);
      reset = 1'b1;
      bus.enable = 1'b0;
      wait_cyc(1);
      chk("mid_rst_up", 32'(bus.up_switches), 0);
      chk("mid_rst_dn", 32'(bus.down_switches), 0);
      chk("mid_rst_busy", 32'(bus.busy), 0);
      chk("mid_rst_ovr", 32'(bus.overrun), 0);
      reset = 1'b0;
      wait_cyc(5);
      chk("queue_empty", 32'(q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/npg_biphasic_gen.md
Name: npg_biphasic_gen

Overview:
- Parametrised next-generation neural pulse generator for the H-bridge stimulator output stage.
- Produces periodic biphasic pulses with programmable:
  - period, phase width and interphase gap;
  - leading polarity;
  - amplitude ramp-up over successive pulses.
- Pulse settings are latched per pulse; overrun is reported.
- Drives up/down switch-enable codes of the current-source bridge directly.

Parameters:
- FREQ_W, 12, width of period register; period = freq+1 clk cycles
- PHASE_W, 8, width of phase-duration register
- GAP_W, 4, width of interphase-gap register
- SW_W, 4, width of up/down switch codes (amplitude code)
- RAMP_W, 6, width of ramp step register (pulses per amplitude step)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous reset, active-high
- enable  in  1  run request
- freq  in  FREQ_W  period minus one, in clk cycles
- phase_dur  in  PHASE_W  cycles per phase; 0 treated as 1
- gap_dur  in  GAP_W  interphase gap cycles; 0 = no gap
- ramp  in  RAMP_W  pulses per amplitude step; 0 = no ramp
- cathodic_first  in  1  0: phase1 up=up_code; 1: phase1 swapped
- up_code  in  SW_W  target up-switch code
- down_code  in  SW_W  target down-switch code
- up_switches  out  SW_W  registered up-switch enables
- down_switches  out  SW_W  registered down-switch enables
- busy  out  1  high while a pulse (PHASE1..PHASE2) is in progress
- overrun  out  1  sticky; period tick arrived while busy
- clr_overrun  in  1  clears overrun

Behaviour:
- Reset (synchronous, high):
  - all outputs 0, state IDLE, counters 0;
  - ramp level = 1.
- Period counter:
  - counts 0..freq while enable is high, then wraps to 0;
  - tick = (count==freq && enable);
  - held at 0 while enable is low.
- FSM states: IDLE, PHASE1, GAP, PHASE2.
  - IDLE: on tick, latch phase_dur, gap_dur, cathodic_first and amplitude codes into shadow registers, then go to PHASE1.
  - PHASE1: lasts max(phase_dur,1) cycles. Exit to GAP if gap_dur != 0, else to PHASE2.
  - GAP: lasts gap_dur cycles, switches 0, then go to PHASE2.
  - PHASE2: lasts max(phase_dur,1) cycles, then go to IDLE (or DISCH, see optional feature).
- Latency: switches become non-zero on the first cycle after the tick edge.
- Outputs are registered from next-state, so they match the state exactly.
- Switch codes:
  - amplitude a_up = min(up_code_lat, level), a_dn = min(down_code_lat, level);
  - PHASE1 with cathodic_first=0: up_switches=a_up, down_switches=a_dn; PHASE2 swapped;
  - cathodic_first=1 inverts this assignment;
  - GAP/IDLE: both 0.
- up and down switches are never both taken from the same source in one cycle; there is no break-before-make here.
- Ramp:
  - ramp==0: level forced to 2^SW_W-1;
  - otherwise a pulse counter increments at each PHASE2 exit; when it reaches ramp, it clears and level increments, saturating at 2^SW_W-1;
  - level and counter reset to 1/0 when enable is low and FSM is IDLE.
- Tick while busy:
  - ignored (no restart) and overrun set;
  - clr_overrun clears it; simultaneous set and clear → set wins.
- enable falling mid-pulse:
  - the current pulse completes fully (charge balance);
  - no new pulse starts.
- Input changes mid-pulse have no effect until the next pulse latch.
- reset mid-pulse: outputs go to 0 on the next edge.

Optional Feature:
- Macro NPG_DISCHARGE_EN.
- When defined:
  - adds output discharge (1 bit, reset 0) and state DISCH after PHASE2;
  - DISCH lasts gap_dur cycles (min 1) with both switch codes 0 and discharge=1;
  - busy stays high during DISCH;
  - a tick during DISCH counts as overrun.
- When undefined: no port and no state; PHASE2 goes straight to IDLE.

Decomposition:
- Package npg_pkg holds:
  - state enum (IDLE, PHASE1, GAP, PHASE2, DISCH);
  - localparam for code max (2^SW_W-1) as a function of SW_W;
  - the min-select helper function.
- One sub-module, npg_ramp, holds level and pulse counter; inputs are pulse_done, ramp, clear.

Test Plan:
- freq=19, phase_dur=3, gap_dur=2, up_code=4'hA, down_code=4'h5, ramp=0, cathodic_first=0 → every 20 cycles: 3 cycles up=A/down=5, 2 cycles zero, 3 cycles up=5/down=A.
- Same as above with cathodic_first=1 → phase order swapped; gap_dur=0 → PHASE2 immediately follows PHASE1.
- ramp=2, up_code=4'hF → up_switches amplitude 1,1,2,2,3,3,… per pulse, saturating at F.
- freq=4, phase_dur=5 → overrun set on first ignored tick; clr_overrun clears it; pulse shape unaffected.
- enable dropped during PHASE1 → pulse completes including PHASE2, then idle; re-enable → ramp restarts at level 1.
- reset asserted during PHASE2 → next cycle all outputs 0, overrun 0; with NPG_DISCHARGE_EN, discharge high for gap_dur cycles after PHASE2.
